jtcps1_gfx_rom_arb: RTL and testbench

//  Arbitrates graphics ROM reads from the four tile layers (OBJ, SCROLL1-3) onto one SDRAM port.

---
 rtl/jtcps1_gfx_rom_arb_pkg.sv | 29 ++
 rtl/jtcps1_gfx_rom_arb_if.sv | 28 ++
 rtl/jtcps1_gfx_rom_arb_rr_arb.sv | 23 ++
 rtl/jtcps1_gfx_rom_arb.sv | 95 +++++++++
 tb/tb_jtcps1_gfx_rom_arb.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jtcps1_gfx_rom_arb_pkg.sv
// Shared constants and types for the CPS1 graphics ROM arbiter: widths,
// layer/type codes and FSM state encoding.
package jtcps1_gfx_rom_arb_pkg;

    localparam int AW     = 23;
    localparam int DW     = 32;
    localparam int NLAYER = 4;
    localparam int LAW    = 20;

    typedef enum logic [1:0] {
        LAYER_OBJ  = 2'd0,
        LAYER_SCR1 = 2'd1,
        LAYER_SCR2 = 2'd2,
        LAYER_SCR3 = 2'd3
    } layer_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ROM type field A[22:20] is the layer index zero-extended
    function automatic logic [2:0] layer_type(input logic [1:0] layer);
        return {1'b0, layer};
    endfunction

endpackage

// File: rtl/jtcps1_gfx_rom_arb_if.sv
// Bus bundle between the arbiter, the layer engines, the bank mapper and the
// SDRAM controller. master = arbiter side, slave = everything around it.
interface jtcps1_gfx_rom_arb_if;
    import jtcps1_gfx_rom_arb_pkg::*;

    logic [NLAYER-1:0]     req;
    logic [NLAYER*LAW-1:0] addr;
    logic [NLAYER-1:0]     ok;
    logic [DW-1:0]         gfx_data;
    logic [2:0]            map_type;
    logic [9:0]            map_code;
    logic [9:0]            map_bank;
    logic [AW-1:0]         rom_addr;
    logic                  rom_cs;
    logic                  rom_ok;
    logic [DW-1:0]         rom_data;

    modport master (
        input  req, addr, map_bank, rom_ok, rom_data,
        output ok, gfx_data, map_type, map_code, rom_addr, rom_cs
    );

    modport slave (
        output req, addr, map_bank, rom_ok, rom_data,
        input  ok, gfx_data, map_type, map_code, rom_addr, rom_cs
    );

endinterface

// File: rtl/jtcps1_gfx_rom_arb_rr_arb.sv
// 4-way round-robin picker: search starts at the layer after the last winner
// and wraps, so the last winner has the lowest priority.
module jtcps1_rr_arb (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] grant_o,
    output logic       any_o
);

    logic [1:0] idx;

    always_comb begin
        grant_o = '0;
        idx     = '0;
        // Scan farthest-first so the nearest requester after last_i overrides
        for (int k = 4; k >= 1; k--) begin
            idx = last_i + 2'(k);
            if (req_i[idx]) grant_o = idx;
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/jtcps1_gfx_rom_arb.sv
// Graphics ROM arbiter: picks one of four layers, resolves its bank through
// the external mapper, runs one SDRAM read and returns the data with ok.
module jtcps1_gfx_rom_arb
    import jtcps1_gfx_rom_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    jtcps1_gfx_rom_arb_if.master  bus
);

    logic [LAW-1:0] layer_addr [NLAYER];

    for (genvar gi = 0; gi < NLAYER; gi++) begin : g_addr
        assign layer_addr[gi] = bus.addr[LAW*gi +: LAW];
    end

    logic [1:0] grant;
    logic       any_req;

    state_t          state_q;
    logic [1:0]      last_q;
    logic [1:0]      winner_q;
    logic            first_q;
    logic [3:0]      ok_q;
    logic [DW-1:0]   gfx_data_q;
    logic [2:0]      map_type_q;
    logic [9:0]      map_code_q;
    logic [AW-1:0]   rom_addr_q;
    logic            rom_cs_q;

    jtcps1_rr_arb u_rr (
        .req_i   (bus.req),
        .last_i  (last_q),
        .grant_o (grant),
        .any_o   (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            // Last winner starts at SCR3 so OBJ is first in line after reset
            last_q     <= 2'd3;
            winner_q   <= 2'd0;
            first_q    <= 1'b0;
            ok_q       <= '0;
            gfx_data_q <= '0;
            map_type_q <= '0;
            map_code_q <= '0;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        winner_q   <= grant;
                        map_type_q <= layer_type(grant);
                        map_code_q <= layer_addr[grant][19:10];
                        state_q    <= ST_MAP;
                    end
                end
                ST_MAP: begin
                    rom_addr_q <= {map_type_q, bus.map_bank, layer_addr[winner_q][9:0]};
                    rom_cs_q   <= 1'b1;
                    first_q    <= 1'b1;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // rom_ok in the first cycle may still belong to the previous access
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (bus.rom_ok) begin
                        rom_cs_q   <= 1'b0;
                        gfx_data_q <= bus.rom_data;
                        ok_q       <= 4'b0001 << winner_q;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ok_q    <= '0;
                    last_q  <= winner_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ok       = ok_q;
    assign bus.gfx_data = gfx_data_q;
    assign bus.map_type = map_type_q;
    assign bus.map_code = map_code_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_cs   = rom_cs_q;

endmodule

// File: tb/tb_jtcps1_gfx_rom_arb.sv
// Directed testbench for the CPS1 graphics ROM arbiter with a behavioural
// bank mapper (bank = code ^ 0x3FF) and an SDRAM responder of set latency.
module tb_jtcps1_gfx_rom_arb;
    import jtcps1_gfx_rom_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtcps1_gfx_rom_arb_if bus ();

    jtcps1_gfx_rom_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.map_bank = bus.map_code ^ 10'h3FF;

    int errors = 0;
    int checks = 0;
    int rom_lat = 2;
    bit rom_always = 1'b0;

    // SDRAM responder: rom_ok once cs has been high rom_lat cycles
    initial begin
        int cnt;
        cnt = 0;
        bus.rom_ok   = 1'b0;
        bus.rom_data = '0;
        forever begin
            @(negedge clk);
            if (bus.rom_cs) cnt++;
            else            cnt = 0;
            bus.rom_ok   = rom_always || (bus.rom_cs && cnt >= rom_lat);
            bus.rom_data = {9'h1AB, bus.rom_addr};
        end
    end

    function automatic logic [31:0] exp_data(input int layer, input logic [19:0] a);
        return {9'h1AB, 3'(layer), a[19:10] ^ 10'h3FF, a[9:0]};
    endfunction

    task automatic set_addr(input int n, input logic [19:0] a);
        bus.addr[20*n +: 20] = a;
    endtask

    task automatic wait_any_ok(output int cyc, output logic [3:0] okv, output logic [31:0] d);
        cyc = -1;
        okv = '0;
        d   = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.ok !== 4'b0000) begin
                cyc = i;
                okv = bus.ok;
                d   = bus.gfx_data;
                break;
            end
        end
        $display("txn ok=%b data=%h cycles=%0d", okv, d, cyc);
    endtask

    task automatic wait_cs(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rom_cs) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req  = '0;
        bus.addr = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.ok !== 4'b0)      begin errors++; $display("FAIL reset_ok got=%b exp=0", bus.ok); end
        checks++; if (bus.gfx_data !== '0)  begin errors++; $display("FAIL reset_data got=%h exp=0", bus.gfx_data); end
        checks++; if (bus.map_type !== '0)  begin errors++; $display("FAIL reset_map_type got=%h exp=0", bus.map_type); end
        checks++; if (bus.map_code !== '0)  begin errors++; $display("FAIL reset_map_code got=%h exp=0", bus.map_code); end
        checks++; if (bus.rom_addr !== '0)  begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", bus.rom_addr); end
        checks++; if (bus.rom_cs !== 1'b0)  begin errors++; $display("FAIL reset_rom_cs got=%b exp=0", bus.rom_cs); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int cyc; logic [3:0] okv; logic [31:0] d;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        rom_lat = 2;
        for (int n = 0; n < 4; n++) set_addr(n, 20'h11111 * (n + 1));
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_any_ok(cyc, okv, d);
            if (i == 4) bus.req = '0;
            checks++; if (okv !== (4'b0001 << order[i])) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, okv, 4'b0001 << order[i]); end
            checks++; if (d !== exp_data(order[i], 20'h11111 * (order[i] + 1))) begin errors++; $display("FAIL rr_data%0d got=%h exp=%h", i, d, exp_data(order[i], 20'h11111 * (order[i] + 1))); end
            checks++; if (cyc !== ((i == 0) ? 4 : 5)) begin errors++; $display("FAIL rr_latency%0d got=%0d exp=%0d", i, cyc, (i == 0) ? 4 : 5); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int cyc; logic [3:0] okv; logic [31:0] d;
        rom_lat = 2;
        set_addr(1, 20'h12345);
        bus.req = 4'b0010;
        wait_any_ok(cyc, okv, d);
        bus.req = '0;
        checks++; if (okv !== 4'b0010)        begin errors++; $display("FAIL single_ok got=%b exp=0010", okv); end
        checks++; if (d !== 32'hD59EDF45)     begin errors++; $display("FAIL single_data got=%h exp=d59edf45", d); end
        checks++; if (cyc !== 4)              begin errors++; $display("FAIL single_latency got=%0d exp=4", cyc); end
        checks++; if (bus.rom_addr !== 23'h1EDF45) begin errors++; $display("FAIL single_rom_addr got=%h exp=1edf45", bus.rom_addr); end
        checks++; if (bus.map_code !== 10'h048) begin errors++; $display("FAIL single_map_code got=%h exp=048", bus.map_code); end
        checks++; if (bus.map_type !== 3'd1)  begin errors++; $display("FAIL single_map_type got=%h exp=1", bus.map_type); end
        checks++; if (bus.rom_cs !== 1'b0)    begin errors++; $display("FAIL single_cs_drop got=%b exp=0", bus.rom_cs); end
        @(negedge clk);
        checks++; if (bus.ok !== 4'b0)        begin errors++; $display("FAIL single_ok_pulse got=%b exp=0", bus.ok); end
        checks++; if (bus.gfx_data !== 32'hD59EDF45) begin errors++; $display("FAIL single_data_hold got=%h exp=d59edf45", bus.gfx_data); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rom_ok_held();
        int cyc; logic [3:0] okv; logic [31:0] d;
        int extra;
        rom_always = 1'b1;
        set_addr(2, 20'hABCDE);
        bus.req = 4'b0100;
        wait_any_ok(cyc, okv, d);
        bus.req = '0;
        checks++; if (cyc !== 4)          begin errors++; $display("FAIL held_latency got=%0d exp=4", cyc); end
        checks++; if (okv !== 4'b0100)    begin errors++; $display("FAIL held_ok got=%b exp=0100", okv); end
        checks++; if (d !== exp_data(2, 20'hABCDE)) begin errors++; $display("FAIL held_data got=%h exp=%h", d, exp_data(2, 20'hABCDE)); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ok !== 4'b0) extra++;
        end
        checks++; if (extra !== 0)        begin errors++; $display("FAIL held_double_ok got=%0d exp=0", extra); end
        rom_always = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop();
        int cyc; logic [3:0] okv; logic [31:0] d;
        bit seen;
        rom_lat = 6;
        set_addr(2, 20'h00F0F);
        set_addr(0, 20'h55555);
        bus.req = 4'b0100;
        wait_cs(seen);
        checks++; if (seen !== 1'b1)      begin errors++; $display("FAIL drop_cs_seen got=%b exp=1", seen); end
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.rom_cs !== 1'b1) begin errors++; $display("FAIL drop_cs_held got=%b exp=1", bus.rom_cs); end
        wait_any_ok(cyc, okv, d);
        checks++; if (okv !== 4'b0100)    begin errors++; $display("FAIL drop_ok got=%b exp=0100", okv); end
        rom_lat = 2;
        @(negedge clk);
        bus.req = 4'b0001;
        wait_any_ok(cyc, okv, d);
        bus.req = '0;
        checks++; if (okv !== 4'b0001)    begin errors++; $display("FAIL drop_next_ok got=%b exp=0001", okv); end
        checks++; if (cyc !== 4)          begin errors++; $display("FAIL drop_next_latency got=%0d exp=4", cyc); end
        checks++; if (d !== exp_data(0, 20'h55555)) begin errors++; $display("FAIL drop_next_data got=%h exp=%h", d, exp_data(0, 20'h55555)); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int cyc; logic [3:0] okv; logic [31:0] d;
        bit seen;
        rom_lat = 10;
        set_addr(3, 20'h7A5C3);
        set_addr(0, 20'h0C0DE);
        bus.req = 4'b1000;
        wait_cs(seen);
        checks++; if (seen !== 1'b1)      begin errors++; $display("FAIL rstw_cs_seen got=%b exp=1", seen); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.rom_cs !== 1'b0)  begin errors++; $display("FAIL rstw_cs got=%b exp=0", bus.rom_cs); end
        checks++; if (bus.ok !== 4'b0)      begin errors++; $display("FAIL rstw_ok got=%b exp=0", bus.ok); end
        checks++; if (bus.rom_addr !== '0)  begin errors++; $display("FAIL rstw_rom_addr got=%h exp=0", bus.rom_addr); end
        bus.req = 4'b1001;
        rom_lat = 2;
        @(negedge clk);
        rst = 1'b0;
        wait_any_ok(cyc, okv, d);
        bus.req = 4'b1000;
        checks++; if (okv !== 4'b0001)    begin errors++; $display("FAIL rstw_first got=%b exp=0001", okv); end
        checks++; if (d !== exp_data(0, 20'h0C0DE)) begin errors++; $display("FAIL rstw_first_data got=%h exp=%h", d, exp_data(0, 20'h0C0DE)); end
        wait_any_ok(cyc, okv, d);
        bus.req = '0;
        checks++; if (okv !== 4'b1000)    begin errors++; $display("FAIL rstw_second got=%b exp=1000", okv); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reraise();
        int cyc; logic [3:0] okv; logic [31:0] d;
        rom_lat = 2;
        set_addr(3, 20'h3C3C3);
        set_addr(0, 20'h81818);
        bus.req = 4'b1000;
        repeat (2) @(negedge clk);
        bus.req = 4'b1001;
        wait_any_ok(cyc, okv, d);
        checks++; if (okv !== 4'b1000)    begin errors++; $display("FAIL reraise_first got=%b exp=1000", okv); end
        wait_any_ok(cyc, okv, d);
        bus.req = 4'b1000;
        checks++; if (okv !== 4'b0001)    begin errors++; $display("FAIL reraise_layer0 got=%b exp=0001", okv); end
        checks++; if (cyc !== 5)          begin errors++; $display("FAIL reraise_gap got=%0d exp=5", cyc); end
        wait_any_ok(cyc, okv, d);
        bus.req = '0;
        checks++; if (okv !== 4'b1000)    begin errors++; $display("FAIL reraise_layer3 got=%b exp=1000", okv); end
        checks++; if (d !== exp_data(3, 20'h3C3C3)) begin errors++; $display("FAIL reraise_data got=%h exp=%h", d, exp_data(3, 20'h3C3C3)); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.req  = '0;
        bus.addr = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_rom_ok_held();
        test_drop();
        test_reset_in_wait();
        test_reraise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
